// File: rtl/set_lru_replacer.sv
// set_lru_replacer
//   Multi-set true-LRU replacement engine. Each set keeps a full age
//   permutation over its ways (age 0 = MRU, NUM_WAYS-1 = LRU). Accesses
//   promote a way to MRU, invalidates demote a way to LRU, and victim
//   queries return the LRU way of a set as a registered one-hot vector.
//
// Ports
//   clk          : clock, all state updates on the rising edge
//   reset        : asynchronous active-high reset
//   access_valid : hit/allocate request
//   access_ready : access accepted (low when an invalidate targets the same set)
//   access_set   : set index of the access
//   access_way   : one-hot way of the access
//   inv_valid    : invalidate request (always accepted)
//   inv_set      : set index of the invalidate
//   inv_way      : one-hot way of the invalidate
//   victim_req   : victim query (always accepted)
//   victim_set   : set index queried
//   victim_valid : victim response strobe, one cycle after victim_req
//   victim_way   : one-hot LRU way, zero while victim_valid is low
//   access_err   : one-cycle pulse after a malformed access/invalidate way
//
// Build option
//   LRU_VICTIM_FWD_EN : when defined, a victim query sees the result of any
//                       same-cycle access/invalidate to its set; otherwise it
//                       sees the pre-update state.

module set_lru_replacer #(
    parameter int NUM_WAYS  = 4,
    parameter int NUM_SETS  = 8,
    parameter int AGE_WIDTH = $clog2(NUM_WAYS),
    parameter int SET_WIDTH = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 access_valid,
    output logic                 access_ready,
    input  logic [SET_WIDTH-1:0] access_set,
    input  logic [NUM_WAYS-1:0]  access_way,
    input  logic                 inv_valid,
    input  logic [SET_WIDTH-1:0] inv_set,
    input  logic [NUM_WAYS-1:0]  inv_way,
    input  logic                 victim_req,
    input  logic [SET_WIDTH-1:0] victim_set,
    output logic                 victim_valid,
    output logic [NUM_WAYS-1:0]  victim_way,
    output logic                 access_err
);

    typedef logic [AGE_WIDTH-1:0] age_t;

    localparam age_t LRU_AGE = age_t'(NUM_WAYS - 1);

    age_t                r_age     [NUM_SETS][NUM_WAYS];
    age_t                w_age_nxt [NUM_SETS][NUM_WAYS];
    logic                r_victim_valid;
    logic [NUM_WAYS-1:0] r_victim_way;
    logic                r_access_err;

    logic                w_acc_fire;
    logic                w_acc_ok;
    logic                w_inv_ok;
    logic                w_acc_apply;
    logic                w_inv_apply;
    logic                w_err;
    age_t                w_acc_old;
    age_t                w_inv_old;
    logic [NUM_WAYS-1:0] w_victim;

    assign access_ready = !(inv_valid && (inv_set == access_set));
    assign w_acc_fire   = access_valid && access_ready;
    assign w_acc_ok     = $onehot(access_way);
    assign w_inv_ok     = $onehot(inv_way);
    assign w_acc_apply  = w_acc_fire && w_acc_ok;
    assign w_inv_apply  = inv_valid && w_inv_ok;
    assign w_err        = (w_acc_fire && !w_acc_ok) || (inv_valid && !w_inv_ok);

    // Old age of the addressed way; OR-reduction is exact because the
    // result is only consumed when the way vector is one-hot.
    always_comb begin
        w_acc_old = '0;
        w_inv_old = '0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            if (access_way[w]) w_acc_old |= r_age[access_set][w];
            if (inv_way[w])    w_inv_old |= r_age[inv_set][w];
        end
    end

    // Access and invalidate can only both apply when they target different
    // sets (ready drops on a same-set collision), so each set sees at most
    // one update and both may read r_age directly.
    always_comb begin
        w_age_nxt = r_age;
        for (int unsigned s = 0; s < NUM_SETS; s++) begin
            for (int unsigned w = 0; w < NUM_WAYS; w++) begin
                if (w_inv_apply && (inv_set == SET_WIDTH'(s))) begin
                    if (inv_way[w])
                        w_age_nxt[s][w] = LRU_AGE;
                    else if (r_age[s][w] > w_inv_old)
                        w_age_nxt[s][w] = r_age[s][w] - age_t'(1);
                end
                if (w_acc_apply && (access_set == SET_WIDTH'(s))) begin
                    if (access_way[w])
                        w_age_nxt[s][w] = '0;
                    else if (r_age[s][w] < w_acc_old)
                        w_age_nxt[s][w] = r_age[s][w] + age_t'(1);
                end
            end
        end
    end

    always_comb begin
        w_victim = '0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
`ifdef LRU_VICTIM_FWD_EN
            if (w_age_nxt[victim_set][w] == LRU_AGE) w_victim[w] = 1'b1;
`else
            if (r_age[victim_set][w] == LRU_AGE) w_victim[w] = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned s = 0; s < NUM_SETS; s++)
                for (int unsigned w = 0; w < NUM_WAYS; w++)
                    r_age[s][w] <= age_t'(w);
            r_victim_valid <= 1'b0;
            r_victim_way   <= '0;
            r_access_err   <= 1'b0;
        end else begin
            r_age          <= w_age_nxt;
            r_victim_valid <= victim_req;
            r_victim_way   <= victim_req ? w_victim : '0;
            r_access_err   <= w_err;
        end
    end

    assign victim_valid = r_victim_valid;
    assign victim_way   = r_victim_way;
    assign access_err   = r_access_err;

endmodule

// File: tb/tb_set_lru_replacer.sv
// tb_set_lru_replacer
//   Directed plus randomized bench for set_lru_replacer (NUM_WAYS=4,
//   NUM_SETS=8). A reference age model predicts victims, which are queued
//   when a query is driven and compared when the response strobe appears.

module tb_set_lru_replacer;

    logic       clk = 1'b0;
    logic       reset;
    logic       access_valid;
    logic       access_ready;
    logic [2:0] access_set;
    logic [3:0] access_way;
    logic       inv_valid;
    logic [2:0] inv_set;
    logic [3:0] inv_way;
    logic       victim_req;
    logic [2:0] victim_set;
    logic       victim_valid;
    logic [3:0] victim_way;
    logic       access_err;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    logic [1:0] m_age [8][4];
    logic [3:0] q_vic [$];
    logic [3:0] last_vic;

    set_lru_replacer #(
        .NUM_WAYS (4),
        .NUM_SETS (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .access_valid (access_valid),
        .access_ready (access_ready),
        .access_set   (access_set),
        .access_way   (access_way),
        .inv_valid    (inv_valid),
        .inv_set      (inv_set),
        .inv_way      (inv_way),
        .victim_req   (victim_req),
        .victim_set   (victim_set),
        .victim_valid (victim_valid),
        .victim_way   (victim_way),
        .access_err   (access_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int s = 0; s < 8; s++)
            for (int w = 0; w < 4; w++)
                m_age[s][w] = 2'(w);
    endtask

    task automatic m_touch(input int s, input logic [3:0] way, input bit inv);
        int         idx;
        logic [1:0] a;
        if (!$onehot(way)) return;
        idx = 0;
        for (int w = 0; w < 4; w++) if (way[w]) idx = w;
        a = m_age[s][idx];
        for (int w = 0; w < 4; w++) begin
            if (w == idx)                   m_age[s][w] = inv ? 2'd3 : 2'd0;
            else if (inv && m_age[s][w] > a)  m_age[s][w] = m_age[s][w] - 2'd1;
            else if (!inv && m_age[s][w] < a) m_age[s][w] = m_age[s][w] + 2'd1;
        end
    endtask

    function automatic logic [3:0] m_victim(input int s);
        logic [3:0] r;
        r = '0;
        for (int w = 0; w < 4; w++) if (m_age[s][w] == 2'd3) r[w] = 1'b1;
        return r;
    endfunction

    task automatic clear_inputs();
        access_valid = 1'b0; access_set = '0; access_way = '0;
        inv_valid    = 1'b0; inv_set    = '0; inv_way    = '0;
        victim_req   = 1'b0; victim_set = '0;
    endtask

    // Inputs are driven after a falling edge; this runs one rising edge,
    // checks all outputs #1 later and returns after the next falling edge
    // with inputs cleared.
    task automatic tick(input string tag);
        bit   exp_ready, fire, err, req;
        logic [3:0] exp_way;
        #1;
        exp_ready = !(inv_valid && (inv_set == access_set));
        check({tag, "/ready"}, 32'(access_ready), 32'(exp_ready));
        fire = access_valid && exp_ready;
        err  = (fire && !$onehot(access_way)) || (inv_valid && !$onehot(inv_way));
        req  = victim_req;
`ifndef LRU_VICTIM_FWD_EN
        if (req) q_vic.push_back(m_victim(int'(victim_set)));
`endif
        if (inv_valid) m_touch(int'(inv_set), inv_way, 1'b1);
        if (fire)      m_touch(int'(access_set), access_way, 1'b0);
`ifdef LRU_VICTIM_FWD_EN
        if (req) q_vic.push_back(m_victim(int'(victim_set)));
`endif
        @(posedge clk); #1;
        check({tag, "/err"}, 32'(access_err), 32'(err));
        check({tag, "/vvalid"}, 32'(victim_valid), 32'(req));
        if (req) begin
            exp_way = q_vic.pop_front();
            check({tag, "/vway"}, 32'(victim_way), 32'(exp_way));
        end else begin
            check({tag, "/vway_idle"}, 32'(victim_way), 32'd0);
        end
        last_vic = victim_way;
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic query(input string tag, input logic [2:0] s);
        victim_req = 1'b1; victim_set = s;
        tick(tag);
    endtask

    initial begin
        clear_inputs();
        m_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst/vvalid", 32'(victim_valid), 32'd0);
        check("rst/vway",   32'(victim_way),   32'd0);
        check("rst/err",    32'(access_err),   32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Reset permutation: way 3 is LRU
        query("q3_reset", 3'd3);
        check("plan/q3_reset", 32'(last_vic), 32'h8);

        // Promote way 3 of set 3; set 4 untouched
        access_valid = 1'b1; access_set = 3'd3; access_way = 4'b1000;
        tick("acc3");
        query("q3_after", 3'd3);
        check("plan/q3_after", 32'(last_vic), 32'h4);
        query("q4_untouched", 3'd4);
        check("plan/q4", 32'(last_vic), 32'h8);

        // Demote way 0 of set 5, twice
        inv_valid = 1'b1; inv_set = 3'd5; inv_way = 4'b0001;
        tick("inv5a");
        query("q5a", 3'd5);
        check("plan/q5a", 32'(last_vic), 32'h1);
        inv_valid = 1'b1; inv_set = 3'd5; inv_way = 4'b0001;
        tick("inv5b");
        query("q5b", 3'd5);
        check("plan/q5b", 32'(last_vic), 32'h1);

        // Same-set collision: invalidate wins, access is held and fires next
        inv_valid = 1'b1; inv_set = 3'd2; inv_way = 4'b0010;
        access_valid = 1'b1; access_set = 3'd2; access_way = 4'b0001;
        tick("collide2");
        access_valid = 1'b1; access_set = 3'd2; access_way = 4'b0001;
        tick("held2");
        query("q2", 3'd2);
        check("plan/q2", 32'(last_vic), 32'h2);

        // Different-set access and invalidate in one cycle
        inv_valid = 1'b1; inv_set = 3'd6; inv_way = 4'b0100;
        access_valid = 1'b1; access_set = 3'd7; access_way = 4'b1000;
        tick("dual67");
        query("q6", 3'd6);
        check("plan/q6", 32'(last_vic), 32'h4);
        query("q7", 3'd7);
        check("plan/q7", 32'(last_vic), 32'h4);

        // Malformed way vectors: error pulse, no state change
        access_valid = 1'b1; access_set = 3'd1; access_way = 4'b0110;
        tick("bad_acc_multi");
        tick("err_clears");
        access_valid = 1'b1; access_set = 3'd1; access_way = 4'b0000;
        tick("bad_acc_zero");
        inv_valid = 1'b1; inv_set = 3'd1; inv_way = 4'b0000;
        tick("bad_inv_zero");
        query("q1_unchanged", 3'd1);
        check("plan/q1", 32'(last_vic), 32'h8);

        // Same-cycle access and victim query on one set
        access_valid = 1'b1; access_set = 3'd1; access_way = 4'b1000;
        victim_req = 1'b1; victim_set = 3'd1;
        tick("acc_q1");
`ifdef LRU_VICTIM_FWD_EN
        check("plan/fwd", 32'(last_vic), 32'h4);
`else
        check("plan/nofwd", 32'(last_vic), 32'h8);
`endif

        // Back-to-back queries
        victim_req = 1'b1; victim_set = 3'd3;
        #1; @(posedge clk); #1;
        n_tests++;
        void'(q_vic.size());
        check("b2b/first_valid", 32'(victim_valid), 32'd1);
        check("b2b/first_way", 32'(victim_way), 32'(m_victim(3)));
        @(negedge clk);
        clear_inputs();
        n_tests--;
        query("b2b_second", 3'd5);

        // Reset while a query is in flight drops the response
        victim_req = 1'b1; victim_set = 3'd3;
        #2 reset = 1'b1;
        @(posedge clk); #1;
        check("rst_mid/vvalid", 32'(victim_valid), 32'd0);
        check("rst_mid/vway",   32'(victim_way),   32'd0);
        @(negedge clk);
        clear_inputs();
        reset = 1'b0;
        m_reset();
        q_vic.delete();
        query("q3_post_reset", 3'd3);
        check("plan/q3_post_reset", 32'(last_vic), 32'h8);

        // Randomized traffic against the model
        for (int i = 0; i < 80; i++) begin
            access_valid = ($urandom_range(0, 1) == 1);
            access_set   = 3'($urandom_range(0, 3));
            access_way   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                                       : 4'(4'b0001 << $urandom_range(0, 3));
            inv_valid    = ($urandom_range(0, 2) == 0);
            inv_set      = 3'($urandom_range(0, 3));
            inv_way      = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                                       : 4'(4'b0001 << $urandom_range(0, 3));
            victim_req   = ($urandom_range(0, 1) == 1);
            victim_set   = 3'($urandom_range(0, 3));
            tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
